// File: rtl/arm_mem_lsu.sv
// Load/store unit: one request at a time, sub-word lane extraction, read-modify-write sub-word stores.
// Optional macro ARM_LSU_ALIGN_CHECK_EN: fault misaligned halfword/word accesses without touching memory.
module arm_mem_lsu #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_excpt,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic        mem_we,
    input  logic        mem_excpt,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RSP  = 2'b11
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic        sgn,
        input logic [1:0]  lo
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_extract = {{24{sgn & b[7]}}, b};
            2'b01:   load_extract = {{16{sgn & h[15]}}, h};
            default: load_extract = word;
        endcase
    endfunction

    // Replace only the addressed lane of the sampled word with the store data.
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  lo
    );
        logic [31:0] m;
        m = word;
        case (size)
            2'b00: begin
                case (lo)
                    2'd0:    m[7:0]   = wdata[7:0];
                    2'd1:    m[15:8]  = wdata[7:0];
                    2'd2:    m[23:16] = wdata[7:0];
                    2'd3:    m[31:24] = wdata[7:0];
                    default: m = word;
                endcase
            end
            2'b01: begin
                if (lo[1]) begin
                    m[31:16] = wdata[15:0];
                end else begin
                    m[15:0] = wdata[15:0];
                end
            end
            default: m = wdata;
        endcase
        store_merge = m;
    endfunction

`ifdef ARM_LSU_ALIGN_CHECK_EN
    // Halfwords need addr[0] clear, words need addr[1:0] clear; bytes never fault.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lo[0];
            default: misaligned = (lo != 2'b00);
        endcase
    endfunction
`endif

    state_t      state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic        we_r, we_s;
    logic [1:0]  size_r, size_s;
    logic        signed_r, signed_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] wdata_r, wdata_s;
    logic        req_ready_r, req_ready_s;
    logic        rsp_valid_r, rsp_valid_s;
    logic [31:0] rsp_rdata_r, rsp_rdata_s;
    logic        rsp_excpt_r, rsp_excpt_s;
    logic [31:0] mem_addr_r, mem_addr_s;
    logic [31:0] mem_data_in_r, mem_data_in_s;
    logic        mem_we_r, mem_we_s;

    // Next-state and next-output logic; outputs are computed one edge ahead so they can be registered.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        we_s          = we_r;
        size_s        = size_r;
        signed_s      = signed_r;
        addr_s        = addr_r;
        wdata_s       = wdata_r;
        rsp_valid_s   = 1'b0;
        rsp_rdata_s   = 32'h0000_0000;
        rsp_excpt_s   = 1'b0;
        mem_addr_s    = 32'h0000_0000;
        mem_data_in_s = 32'h0000_0000;
        mem_we_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    we_s     = req_we;
                    size_s   = req_size;
                    signed_s = req_signed;
                    addr_s   = req_addr;
                    wdata_s  = req_wdata;
                    cnt_s    = 3'd0;
`ifdef ARM_LSU_ALIGN_CHECK_EN
                    if (misaligned(req_size, req_addr[1:0])) begin
                        state_s     = RSP;
                        rsp_valid_s = 1'b1;
                        rsp_excpt_s = 1'b1;
                    end else
`endif
                    if (req_we && req_size[1]) begin
                        state_s       = WR;
                        mem_addr_s    = {req_addr[31:2], 2'b00};
                        mem_data_in_s = req_wdata;
                        mem_we_s      = 1'b1;
                    end else begin
                        state_s    = RD;
                        mem_addr_s = {req_addr[31:2], 2'b00};
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                mem_addr_s = {addr_r[31:2], 2'b00};
                if (cnt_r == LAST_CNT) begin
                    // A read fault ends the request here; the write phase is never entered.
                    if (mem_excpt) begin
                        state_s     = RSP;
                        mem_addr_s  = 32'h0000_0000;
                        rsp_valid_s = 1'b1;
                        rsp_excpt_s = 1'b1;
                    end else if (we_r) begin
                        state_s       = WR;
                        mem_data_in_s = store_merge(mem_data_out, wdata_r, size_r, addr_r[1:0]);
                        mem_we_s      = 1'b1;
                    end else begin
                        state_s     = RSP;
                        mem_addr_s  = 32'h0000_0000;
                        rsp_valid_s = 1'b1;
                        rsp_rdata_s = load_extract(mem_data_out, size_r, signed_r, addr_r[1:0]);
                    end
                end else begin
                    cnt_s = cnt_r + 3'd1;
                end
            end
            WR: begin
                state_s     = RSP;
                rsp_valid_s = 1'b1;
                rsp_excpt_s = mem_excpt;
            end
            RSP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        req_ready_s = (state_s == IDLE);
    end

    // State, captured request fields and all outputs; reset clears everything except req_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= 3'd0;
            we_r          <= 1'b0;
            size_r        <= 2'b00;
            signed_r      <= 1'b0;
            addr_r        <= 32'h0000_0000;
            wdata_r       <= 32'h0000_0000;
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= 32'h0000_0000;
            rsp_excpt_r   <= 1'b0;
            mem_addr_r    <= 32'h0000_0000;
            mem_data_in_r <= 32'h0000_0000;
            mem_we_r      <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            we_r          <= we_s;
            size_r        <= size_s;
            signed_r      <= signed_s;
            addr_r        <= addr_s;
            wdata_r       <= wdata_s;
            req_ready_r   <= req_ready_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_excpt_r   <= rsp_excpt_s;
            mem_addr_r    <= mem_addr_s;
            mem_data_in_r <= mem_data_in_s;
            mem_we_r      <= mem_we_s;
        end
    end

    assign req_ready   = req_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_excpt   = rsp_excpt_r;
    assign mem_addr    = mem_addr_r;
    assign mem_data_in = mem_data_in_r;
    assign mem_we      = mem_we_r;

endmodule

// File: doc/arm_mem_lsu.md
ARM_MEM_LSU -- requirements
Module: arm_mem_lsu

Interface
REQ-001 SHALL provide parameter: RD_LAT, default 1, number of cycles a read address is held on the memory port before mem_data_out is sampled (legal 1..4).
REQ-002 SHALL provide these ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word; 11 reserved, treated as word.
- req_signed  input  1  sign-extend sub-word loads.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  32  load result.
- rsp_excpt  output  1  access faulted.
- mem_addr  output  32  word address to memory port (low 2 bits always 0).
- mem_data_in  output  32  write data to memory port.
- mem_we  output  1  memory write enable.
- mem_excpt  input  1  memory port exception.
- mem_data_out  input  32  memory read data, combinational from mem_addr.

Function
REQ-003 SHALL use an FSM with states IDLE, RD, WR, RSP; req_ready = 1 only in IDLE.
REQ-004 SHALL accept a request on a rising edge with req_valid & req_ready and register all req_* fields.
REQ-005 SHALL use little-endian lanes: byte k = bits [8k+7:8k] with k = addr[1:0]; halfword at addr[1] = h occupies bits [16h+15:16h].
REQ-006 SHALL route an accepted load to RD, a word store to WR, and a byte/halfword store to RD, then WR (read-modify-write).
REQ-007 SHALL drive mem_addr = {addr[31:2],2'b00} in RD and WR; mem_addr, mem_data_in, and mem_we SHALL be 0 in IDLE and RSP.
REQ-008 SHALL remain in RD for exactly RD_LAT cycles and sample mem_data_out and mem_excpt on the final RD edge.
REQ-009 SHALL, for loads, extract the addressed lane and zero-extend it, or sign-extend it when req_signed = 1; word loads SHALL pass the data through unchanged.
REQ-010 SHALL, for sub-word stores, drive mem_data_in in WR as the sampled word with only the addressed lane replaced by the low bits of req_wdata.
REQ-011 SHALL assert mem_we for exactly one cycle, in WR only.
REQ-012 SHALL, if mem_excpt is sampled high in RD, skip WR, go to RSP with rsp_excpt = 1, and never assert mem_we for that request.
REQ-013 SHALL sample mem_excpt during WR into rsp_excpt.
REQ-014 SHALL hold rsp_valid = 1 for exactly one cycle in RSP, then return to IDLE.
REQ-015 SHALL drive rsp_rdata = 0 for stores and faulted accesses, and rsp_rdata and rsp_excpt = 0 whenever rsp_valid = 0.
REQ-016 SHALL meet this latency from the acceptance edge to the rsp_valid cycle, with RD_LAT = 1:
- load: 2 cycles
- word store: 2 cycles
- sub-word store: 3 cycles
- misaligned fault: 1 cycle
REQ-017 SHALL ignore req_valid while not in IDLE, with no queuing.

Reset
REQ-018 SHALL, on rst_n low, immediately force IDLE with req_ready = 1 and all other outputs = 0.
REQ-019 SHALL drop an in-flight request when reset asserts mid-operation: no response, mem_we deasserted asynchronously.
REQ-020 SHALL accept its first request on the first rising edge after rst_n rises.

Configuration
REQ-021 SHALL honour macro ARM_LSU_ALIGN_CHECK_EN.
- Defined: a halfword with addr[0] = 1, or a word with addr[1:0] != 0, SHALL go IDLE->RSP with rsp_excpt = 1 and no memory access.
- Undefined: misaligned low bits SHALL be ignored (halfword uses addr[1] only, word ignores addr[1:0]) with no exception.

Verification
REQ-022 Word store 0x1f1e003b @0x10, then word load @0x10 -> mem_we high for one cycle; rsp_rdata = 0x1f1e003b two cycles after acceptance.
REQ-023 Byte store 0xAA @0x11, then word load @0x10 -> RD then WR with mem_data_in = 0x1f1eAA3b; the load returns 0x1f1eAA3b.
REQ-024 Byte load @0x11 -> signed returns 0xFFFFFFAA; unsigned returns 0x000000AA.
REQ-025 Halfword load @0x13:
- with the macro: rsp_excpt = 1 one cycle after acceptance, with mem_addr staying 0;
- without the macro: returns 0x00001f1e.
REQ-026 Halfword store @0x10 with mem_excpt forced high during RD -> rsp_excpt = 1, mem_we never asserted, memory word unchanged.
REQ-027 rst_n pulsed low during WR of a byte store -> mem_we drops the same cycle, no rsp_valid, req_ready = 1; the next request completes normally.
